// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared types for the FIFO write-side arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE = arbitrating, GRANT = a
//                 requester owns the FIFO write port).
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : fifo_wr_arbiter_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_rr_pick
// Combinational round-robin priority picker. Scans requests starting at the
// index after i_rr_ptr and wraps modulo N_REQ, so the last winner has the
// lowest priority.
// Ports:
//   i_req     in  N_REQ  request vector
//   i_rr_ptr  in  ID_W   index of the most recent winner
//   o_any     out 1      at least one request asserted
//   o_winner  out ID_W   selected index (0 when o_any is low)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic             o_any,
  output logic [ID_W-1:0]  o_winner
);

  logic            any_s;
  logic [ID_W-1:0] winner_s;

  // First asserted request after the pointer, wrapping; earliest hit sticks.
  always_comb begin
    any_s    = 1'b0;
    winner_s = {ID_W{1'b0}};
    for (int i = 1; i <= N_REQ; i++) begin
      winner_s = (!any_s && i_req[(int'(i_rr_ptr) + i) % N_REQ])
                 ? ID_W'((int'(i_rr_ptr) + i) % N_REQ) : winner_s;
      any_s    = any_s | i_req[(int'(i_rr_ptr) + i) % N_REQ];
    end
  end

  assign o_any    = any_s;
  assign o_winner = winner_s;

endmodule : fifo_wr_arbiter_rr_pick

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of the dual-clock FIFO among N_REQ requesters
// in the write clock domain. Round-robin, burst-locked grants; a grant lasts
// until the requester's last beat or MAX_BURST beats, whichever comes first.
// Each written beat carries the source requester ID as sideband.
// Ports:
//   i_w_clk       in  1            write-domain clock
//   i_wresetn     in  1            async active-low reset
//   i_req_valid   in  N_REQ        per-requester beat valid
//   i_req_last    in  N_REQ        per-requester last beat (qualified by valid)
//   i_req_data    in  N_REQ*WIDTH  packed beats, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready   out N_REQ        beat accepted this cycle
//   i_fifo_full   in  1            FIFO full flag
//   o_fifo_we     out 1            FIFO write enable
//   o_fifo_wdata  out WIDTH        FIFO write data
//   o_fifo_wid    out ID_W         source ID of the current beat
//   o_grant       out N_REQ        registered one-hot grant
//   o_busy        out 1            high while in GRANT
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                     i_w_clk,
  input  logic                     i_wresetn,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ-1:0]         i_req_last,
  input  logic [N_REQ*WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_we,
  output logic [WIDTH-1:0]         o_fifo_wdata,
  output logic [$clog2(N_REQ)-1:0] o_fifo_wid,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q,     state_d;
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [ID_W-1:0]  grant_idx_q, grant_idx_d;
  logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0] grant_q,     grant_d;
  logic             busy_q,      busy_d;

  logic             any_s;
  logic [ID_W-1:0]  winner_s;
  logic             beat_s;
  logic [N_REQ-1:0] ready_s;
  logic [BC_W-1:0]  burst_inc_s;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .i_req    (i_req_valid),
    .i_rr_ptr (rr_ptr_q),
    .o_any    (any_s),
    .o_winner (winner_s)
  );

  // State register: pointer reset to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge i_w_clk or negedge i_wresetn) begin
    if (!i_wresetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      grant_idx_q <= {ID_W{1'b0}};
      burst_cnt_q <= {BC_W{1'b0}};
      grant_q     <= {N_REQ{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign burst_inc_s = burst_cnt_q + BC_W'(1);

  // Next-state: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    burst_cnt_d = burst_cnt_q;
    grant_d     = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d     = ST_GRANT;
          rr_ptr_d    = winner_s;
          grant_idx_d = winner_s;
          burst_cnt_d = {BC_W{1'b0}};
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A stalled cycle (full or valid low) leaves the counter frozen;
        // last only counts on the cycle the beat actually transfers.
        if (beat_s) begin
          if (i_req_last[grant_idx_q] || (burst_inc_s == BC_W'(MAX_BURST))) begin
            state_d     = ST_IDLE;
            grant_d     = {N_REQ{1'b0}};
            burst_cnt_d = {BC_W{1'b0}};
          end else begin
            burst_cnt_d = burst_inc_s;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = {N_REQ{1'b0}};
        burst_cnt_d = {BC_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_GRANT);
  end

  // Outputs: only the granted requester sees ready, and only when not full.
  always_comb begin
    beat_s  = 1'b0;
    ready_s = {N_REQ{1'b0}};
    case (state_q)
      ST_GRANT: begin
        beat_s               = i_req_valid[grant_idx_q] & ~i_fifo_full;
        ready_s[grant_idx_q] = ~i_fifo_full;
      end
      ST_IDLE: begin
        beat_s  = 1'b0;
        ready_s = {N_REQ{1'b0}};
      end
      default: begin
        beat_s  = 1'b0;
        ready_s = {N_REQ{1'b0}};
      end
    endcase
  end

  assign o_req_ready  = ready_s;
  assign o_fifo_we    = beat_s;
  assign o_fifo_wdata = i_req_data[int'(grant_idx_q)*WIDTH +: WIDTH];
  assign o_fifo_wid   = grant_idx_q;
  assign o_grant      = grant_q;
  assign o_busy       = busy_q;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed testbench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=8).
// Inputs are driven 1 time unit after the rising edge and outputs are checked
// one further unit later. A monitor records every FIFO write as {wid, wdata}.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  valid;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  ready;
  logic        full;
  logic        we;
  logic [7:0]  wdata;
  logic [1:0]  wid;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [9:0] mon_q[$];

  fifo_wr_arbiter #(
    .N_REQ     (N_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_w_clk      (clk),
    .i_wresetn    (rstn),
    .i_req_valid  (valid),
    .i_req_last   (last),
    .i_req_data   (data),
    .o_req_ready  (ready),
    .i_fifo_full  (full),
    .o_fifo_we    (we),
    .o_fifo_wdata (wdata),
    .o_fifo_wid   (wid),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we === 1'b1) mon_q.push_back({wid, wdata});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 4'h0; last = 4'h0; full = 1'b0; data = 32'h44332211;
    step(); step(); #1;
    checks++;
    if ({grant, busy, we, ready, wid, wdata} !== {4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 8'h11}) begin
      errors++;
      $display("FAIL reset_state: got grant=%b busy=%b we=%b ready=%b wid=%0d wdata=%h, exp 0000 0 0 0000 0 11",
               grant, busy, we, ready, wid, wdata);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [9:0] exp_q[$];
    mon_q.delete();
    valid = 4'b0010; last = 4'h0; data[15:8] = 8'hA1; #1;
    checks++;
    if ({busy, we} !== 2'b00) begin
      errors++; $display("FAIL single_idle: got busy=%b we=%b, exp 0 0", busy, we);
    end
    step(); #1;
    checks++;
    if ({grant, busy, we, wid, wdata, ready} !== {4'b0010, 1'b1, 1'b1, 2'd1, 8'hA1, 4'b0010}) begin
      errors++;
      $display("FAIL single_grant: got grant=%b busy=%b we=%b wid=%0d wdata=%h ready=%b, exp 0010 1 1 1 a1 0010",
               grant, busy, we, wid, wdata, ready);
    end
    step(); data[15:8] = 8'hA2; #1;
    checks++;
    if ({we, wdata} !== {1'b1, 8'hA2}) begin
      errors++; $display("FAIL single_beat2: got we=%b wdata=%h, exp 1 a2", we, wdata);
    end
    step(); data[15:8] = 8'hA3; last = 4'b0010; #1;
    checks++;
    if ({we, wdata} !== {1'b1, 8'hA3}) begin
      errors++; $display("FAIL single_beat3: got we=%b wdata=%h, exp 1 a3", we, wdata);
    end
    step(); valid = 4'h0; last = 4'h0; #1;
    checks++;
    if ({grant, busy, we} !== {4'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_release: got grant=%b busy=%b we=%b, exp 0000 0 0", grant, busy, we);
    end
    exp_q = '{{2'd1, 8'hA1}, {2'd1, 8'hA2}, {2'd1, 8'hA3}};
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count: got %0d writes, exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_fifo[%0d]: got %h, exp %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [9:0] exp_q[$];
    rstn = 1'b0; step(); rstn = 1'b1;
    mon_q.delete();
    valid = 4'hF; last = 4'hF; data = 32'hD3D2D1D0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if ({busy, we} !== 2'b00) begin
        errors++; $display("FAIL rr_bubble[%0d]: got busy=%b we=%b, exp 0 0", k, busy, we);
      end
      step(); #1;
      exp_g = 4'b0001 << (k % 4);
      checks++;
      if ({grant, we, wid, wdata} !== {exp_g, 1'b1, 2'(k % 4), 8'(8'hD0 + k % 4)}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got grant=%b we=%b wid=%0d wdata=%h, exp %b 1 %0d %h",
                 k, grant, we, wid, wdata, exp_g, k % 4, 8'(8'hD0 + k % 4));
      end
      step();
    end
    valid = 4'h0; last = 4'h0;
    for (int k = 0; k < 8; k++) exp_q.push_back({2'(k % 4), 8'(8'hD0 + k % 4)});
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rr_count: got %0d writes, exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_fifo[%0d]: got %h, exp %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_max_burst();
    logic [9:0] exp_q[$];
    mon_q.delete();
    valid = 4'b0100; last = 4'h0; data[23:16] = 8'h20;
    step();
    valid = 4'b0101; last = 4'b0001; data[7:0] = 8'h0F;
    for (int n = 0; n < 8; n++) begin
      #1;
      checks++;
      if ({we, wid, wdata, ready} !== {1'b1, 2'd2, 8'(8'h20 + n), 4'b0100}) begin
        errors++;
        $display("FAIL burst_a[%0d]: got we=%b wid=%0d wdata=%h ready=%b, exp 1 2 %h 0100",
                 n, we, wid, wdata, ready, 8'(8'h20 + n));
      end
      step(); data[23:16] = 8'(8'h21 + n);
    end
    #1;
    checks++;
    if ({busy, grant} !== {1'b0, 4'h0}) begin
      errors++; $display("FAIL burst_forced_release: got busy=%b grant=%b, exp 0 0000", busy, grant);
    end
    step(); #1;
    checks++;
    if ({grant, wid, wdata, we} !== {4'b0001, 2'd0, 8'h0F, 1'b1}) begin
      errors++;
      $display("FAIL burst_other: got grant=%b wid=%0d wdata=%h we=%b, exp 0001 0 0f 1", grant, wid, wdata, we);
    end
    step(); valid = 4'b0100; last = 4'h0;
    step();
    for (int n = 8; n < 16; n++) begin
      #1;
      checks++;
      if ({grant, we, wid, wdata} !== {4'b0100, 1'b1, 2'd2, 8'(8'h20 + n)}) begin
        errors++;
        $display("FAIL burst_b[%0d]: got grant=%b we=%b wid=%0d wdata=%h, exp 0100 1 2 %h",
                 n, grant, we, wid, wdata, 8'(8'h20 + n));
      end
      step(); data[23:16] = 8'(8'h21 + n);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL burst_b_release: got busy=%b, exp 0", busy);
    end
    step();
    for (int n = 16; n < 20; n++) begin
      if (n == 19) last = 4'b0100;
      #1;
      checks++;
      if ({grant, we, wdata} !== {4'b0100, 1'b1, 8'(8'h20 + n)}) begin
        errors++;
        $display("FAIL burst_c[%0d]: got grant=%b we=%b wdata=%h, exp 0100 1 %h", n, grant, we, wdata, 8'(8'h20 + n));
      end
      step(); data[23:16] = 8'(8'h21 + n);
    end
    valid = 4'h0; last = 4'h0; #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL burst_c_release: got busy=%b, exp 0", busy);
    end
    for (int n = 0; n < 8; n++) exp_q.push_back({2'd2, 8'(8'h20 + n)});
    exp_q.push_back({2'd0, 8'h0F});
    for (int n = 8; n < 20; n++) exp_q.push_back({2'd2, 8'(8'h20 + n)});
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL burst_count: got %0d writes, exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL burst_fifo[%0d]: got %h, exp %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [9:0] exp_q[$];
    mon_q.delete();
    valid = 4'b1000; last = 4'h0; full = 1'b0; data[31:24] = 8'h31;
    step();
    for (int n = 0; n < 8; n++) begin
      if (n == 2) begin
        full = 1'b1;
        for (int s = 0; s < 5; s++) begin
          #1;
          checks++;
          if ({we, ready, grant, busy} !== {1'b0, 4'h0, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL full_stall[%0d]: got we=%b ready=%b grant=%b busy=%b, exp 0 0000 1000 1",
                     s, we, ready, grant, busy);
          end
          step();
        end
        full = 1'b0;
      end
      #1;
      checks++;
      if ({we, wid, wdata, ready} !== {1'b1, 2'd3, 8'(8'h31 + n), 4'b1000}) begin
        errors++;
        $display("FAIL full_beat[%0d]: got we=%b wid=%0d wdata=%h ready=%b, exp 1 3 %h 1000",
                 n, we, wid, wdata, ready, 8'(8'h31 + n));
      end
      step(); data[31:24] = 8'(8'h32 + n);
    end
    #1;
    checks++;
    if ({busy, grant} !== {1'b0, 4'h0}) begin
      errors++; $display("FAIL full_max_release: got busy=%b grant=%b, exp 0 0000", busy, grant);
    end
    step(); last = 4'b1000; full = 1'b1; #1;
    checks++;
    if ({we, ready} !== {1'b0, 4'h0}) begin
      errors++; $display("FAIL full_last_stall: got we=%b ready=%b, exp 0 0000", we, ready);
    end
    step(); #1;
    checks++;
    if ({busy, grant} !== {1'b1, 4'b1000}) begin
      errors++; $display("FAIL full_last_hold: got busy=%b grant=%b, exp 1 1000", busy, grant);
    end
    full = 1'b0; #1;
    checks++;
    if ({we, wdata} !== {1'b1, 8'h39}) begin
      errors++; $display("FAIL full_last_beat: got we=%b wdata=%h, exp 1 39", we, wdata);
    end
    step(); valid = 4'h0; last = 4'h0; #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL full_last_release: got busy=%b, exp 0", busy);
    end
    for (int n = 0; n < 9; n++) exp_q.push_back({2'd3, 8'(8'h31 + n)});
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_count: got %0d writes, exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_fifo[%0d]: got %h, exp %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp_q[$];
    mon_q.delete();
    valid = 4'b0010; last = 4'h0; data[15:8] = 8'h61;
    step(); #1;
    checks++;
    if ({grant, we, wdata} !== {4'b0010, 1'b1, 8'h61}) begin
      errors++; $display("FAIL rstmid_grant: got grant=%b we=%b wdata=%h, exp 0010 1 61", grant, we, wdata);
    end
    step(); data[15:8] = 8'h62; step();
    data[15:8] = 8'h63; rstn = 1'b0;
    valid = 4'b0011; data[7:0] = 8'h71; last = 4'b0001; #1;
    checks++;
    if ({grant, we, busy, ready} !== {4'h0, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL rstmid_drop: got grant=%b we=%b busy=%b ready=%b, exp 0000 0 0 0000", grant, we, busy, ready);
    end
    step(); rstn = 1'b1;
    step(); #1;
    checks++;
    if ({grant, wid, wdata, we} !== {4'b0001, 2'd0, 8'h71, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_restart: got grant=%b wid=%0d wdata=%h we=%b, exp 0001 0 71 1", grant, wid, wdata, we);
    end
    step(); valid = 4'h0; last = 4'h0;
    exp_q = '{{2'd1, 8'h61}, {2'd1, 8'h62}, {2'd0, 8'h71}};
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count: got %0d writes, exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_fifo[%0d]: got %h, exp %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [9:0] exp_q[$];
    mon_q.delete();
    valid = 4'b0010; last = 4'h0; data[15:8] = 8'h51;
    step();
    valid = 4'b1011; last = 4'b1001; data[7:0] = 8'h0A; data[31:24] = 8'h3A; #1;
    checks++;
    if ({grant, we, wdata} !== {4'b0010, 1'b1, 8'h51}) begin
      errors++; $display("FAIL drop_first: got grant=%b we=%b wdata=%h, exp 0010 1 51", grant, we, wdata);
    end
    step(); valid = 4'b1001;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if ({we, grant, ready} !== {1'b0, 4'b0010, 4'b0010}) begin
        errors++;
        $display("FAIL drop_hold[%0d]: got we=%b grant=%b ready=%b, exp 0 0010 0010", s, we, grant, ready);
      end
      step();
    end
    valid = 4'b1011; last = 4'b1011; data[15:8] = 8'h52; #1;
    checks++;
    if ({we, wdata, grant} !== {1'b1, 8'h52, 4'b0010}) begin
      errors++; $display("FAIL drop_resume: got we=%b wdata=%h grant=%b, exp 1 52 0010", we, wdata, grant);
    end
    step(); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_release: got busy=%b, exp 0", busy);
    end
    step(); #1;
    checks++;
    if ({grant, wid, wdata} !== {4'b1000, 2'd3, 8'h3A}) begin
      errors++; $display("FAIL drop_next: got grant=%b wid=%0d wdata=%h, exp 1000 3 3a", grant, wid, wdata);
    end
    step(); valid = 4'h0; last = 4'h0;
    exp_q = '{{2'd1, 8'h51}, {2'd1, 8'h52}, {2'd3, 8'h3A}};
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drop_count: got %0d writes, exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL drop_fifo[%0d]: got %h, exp %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_fifo_full();
    test_reset_mid();
    test_valid_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
